// File: rtl/cordic_init_stage.sv
// Front stage of the pipelined CORDIC: folds the target into +/-pi/2, emits the initial vector,
// and tracks valid/negate flags aligned to the last step. Fold logic exists only with CORDIC_FOLD_EN.
module cordic_init_stage #(
  parameter int W       = 12,
  parameter int STEPS   = 12,
  parameter int KINIT   = 622,
  parameter int HALF_PI = 1608,
  parameter int PI      = 3217,
  parameter int CW      = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ce,
  input  logic                in_valid,
  input  logic signed [W-1:0] t_angle_in,
  output logic signed [W-1:0] cos_out,
  output logic signed [W-1:0] sin_out,
  output logic signed [W-1:0] angle_out,
  output logic signed [W-1:0] t_angle_out,
  output logic                valid_tail,
  output logic                neg_tail,
  output logic [CW-1:0]       inflight
);

  if (((1 << CW) <= (STEPS + 1)) || (HALF_PI >= PI)) begin : g_bad_params
    $error("cordic_init_stage: CW too narrow for STEPS+1 or HALF_PI >= PI");
  end

  logic signed [W-1:0] t_fold;
  logic [STEPS:0]      vld;

`ifdef CORDIC_FOLD_EN
  localparam int XW = W + 2;
  localparam logic signed [XW-1:0] HALF_PI_X = XW'(HALF_PI);
  localparam logic signed [XW-1:0] PI_X      = XW'(PI);

  logic signed [XW-1:0] t_ext;
  logic signed [XW-1:0] t_alt;
  logic                 fold_neg;
  logic [STEPS:0]       neg;

  // Exactly +/-HALF_PI stays unfolded; the folded magnitude never exceeds HALF_PI, so W bits suffice.
  always_comb begin
    t_ext    = {{(XW-W){t_angle_in[W-1]}}, t_angle_in};
    t_alt    = t_ext;
    fold_neg = 1'b0;
    if (t_ext > HALF_PI_X) begin
      t_alt    = PI_X - t_ext;
      fold_neg = 1'b1;
    end else if (t_ext < -HALF_PI_X) begin
      t_alt    = -PI_X - t_ext;
      fold_neg = 1'b1;
    end
    t_fold = t_alt[W-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      neg <= '0;
    end else if (ce) begin
      neg <= {neg[STEPS-1:0], in_valid & fold_neg};
    end
  end

  assign neg_tail = neg[STEPS];
`else
  assign t_fold   = t_angle_in;
  assign neg_tail = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cos_out     <= '0;
      sin_out     <= '0;
      angle_out   <= '0;
      t_angle_out <= '0;
      vld         <= '0;
      inflight    <= '0;
    end else if (ce) begin
      vld      <= {vld[STEPS-1:0], in_valid};
      // The tail bit leaves on the same edge a new sample may enter.
      inflight <= inflight + CW'(in_valid) - CW'(vld[STEPS]);
      if (in_valid) begin
        t_angle_out <= t_fold;
        cos_out     <= W'(KINIT);
        sin_out     <= '0;
        angle_out   <= '0;
      end
    end
  end

  assign valid_tail = vld[STEPS];

endmodule

// File: tb/tb_cordic_init_stage.sv
// Randomized bench for cordic_init_stage against a queue-based model of per-edge sample history.
module tb_cordic_init_stage;
  localparam int W     = 12;
  localparam int STEPS = 12;
  localparam int CW    = 5;
  localparam int VW    = 4*W + 2 + CW;
  typedef logic [VW-1:0] vec_t;

  logic                clock = 1'b0;
  logic                reset;
  logic                ce;
  logic                in_valid;
  logic signed [W-1:0] t_angle_in;
  logic signed [W-1:0] cos_out;
  logic signed [W-1:0] sin_out;
  logic signed [W-1:0] angle_out;
  logic signed [W-1:0] t_angle_out;
  logic                valid_tail;
  logic                neg_tail;
  logic [CW-1:0]       inflight;

  int tests = 0;
  int fails = 0;

  // Model: one entry per ce-enabled edge since reset, holding what entered that edge.
  bit vh[$];
  bit nh[$];
  int exp_t;
  int exp_cos;

  always #5 clock = ~clock;

  cordic_init_stage dut (
    .clock      (clock),
    .reset      (reset),
    .ce         (ce),
    .in_valid   (in_valid),
    .t_angle_in (t_angle_in),
    .cos_out    (cos_out),
    .sin_out    (sin_out),
    .angle_out  (angle_out),
    .t_angle_out(t_angle_out),
    .valid_tail (valid_tail),
    .neg_tail   (neg_tail),
    .inflight   (inflight)
  );

  function automatic void fold(input int t, output int tp, output bit ng);
`ifdef CORDIC_FOLD_EN
    if (t > 1608) begin
      tp = 3217 - t;
      ng = 1'b1;
    end else if (t < -1608) begin
      tp = -3217 - t;
      ng = 1'b1;
    end else begin
      tp = t;
      ng = 1'b0;
    end
`else
    tp = t;
    ng = 1'b0;
`endif
  endfunction

  function automatic void model_clear();
    vh.delete();
    nh.delete();
    exp_t   = 0;
    exp_cos = 0;
  endfunction

  function automatic vec_t exp_vec();
    logic [W-1:0] c;
    logic [W-1:0] tt;
    bit vt;
    bit nt;
    int inf;
    int sz;
    int start;
    c   = exp_cos[W-1:0];
    tt  = exp_t[W-1:0];
    vt  = 1'b0;
    nt  = 1'b0;
    inf = 0;
    sz  = vh.size();
    if (sz > STEPS) begin
      vt = vh[sz-1-STEPS];
      nt = nh[sz-1-STEPS];
    end
    start = (sz > STEPS + 1) ? sz - STEPS - 1 : 0;
    for (int i = start; i < sz; i++) inf += int'(vh[i]);
    return {c, {W{1'b0}}, {W{1'b0}}, tt, vt, nt, inf[CW-1:0]};
  endfunction

  function automatic vec_t obs_vec();
    return {cos_out, sin_out, angle_out, t_angle_out, valid_tail, neg_tail, inflight};
  endfunction

  function automatic int rand_angle();
    return int'($urandom_range(4095)) - 2048;
  endfunction

  task automatic cycle(input bit c, input bit v, input int t);
    int tp;
    bit ng;
    ce         = c;
    in_valid   = v;
    t_angle_in = t[W-1:0];
    @(posedge clock);
    #1;
    if (reset) begin
      model_clear();
    end else if (c) begin
      fold(t, tp, ng);
      vh.push_back(v);
      nh.push_back(v & ng);
      if (v) begin
        exp_t   = tp;
        exp_cos = 622;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cycle(1'b1, 1'b0, 0);
    tests++;
    if (obs_vec() !== '0) begin
      fails++;
      $display("FAIL reset_hold got=%h exp=0", obs_vec());
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 0);
      tests++;
      if (obs_vec() !== exp_vec() || inflight !== '0) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_no_fold();
    int pulses = 0;
    cycle(1'b1, 1'b1, 512);
    tests++;
    if ({t_angle_out, cos_out, sin_out} !== {12'sd512, 12'sd622, 12'sd0}) begin
      fails++;
      $display("FAIL no_fold_load got t=%0d cos=%0d sin=%0d exp t=512 cos=622 sin=0",
               t_angle_out, cos_out, sin_out);
    end
    for (int k = 1; k <= 16; k++) begin
      cycle(1'b1, 1'b0, rand_angle());
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL no_fold_model k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (valid_tail === 1'b1) begin
        pulses++;
        tests++;
        if (k != STEPS || neg_tail !== 1'b0) begin
          fails++;
          $display("FAIL no_fold_tail got k=%0d neg=%b exp k=%0d neg=0", k, neg_tail, STEPS);
        end
      end
    end
    tests++;
    if (pulses != 1) begin
      fails++;
      $display("FAIL no_fold_pulses got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_fold_b2b();
    int vals[5] = '{1608, 1609, 2047, -1609, -2048};
`ifdef CORDIC_FOLD_EN
    int tlit[5] = '{1608, 1608, 1170, -1608, -1169};
    bit nlit[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`else
    int tlit[5] = '{1608, 1609, 2047, -1609, -2048};
    bit nlit[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    int idx = 0;
    for (int j = 0; j < 5; j++) begin
      cycle(1'b1, 1'b1, vals[j]);
      tests++;
      if (t_angle_out !== W'(tlit[j])) begin
        fails++;
        $display("FAIL fold_t j=%0d got=%0d exp=%0d", j, t_angle_out, tlit[j]);
      end
    end
    for (int k = 1; k <= 16; k++) begin
      cycle(1'b1, 1'b0, 0);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL fold_model k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (valid_tail === 1'b1) begin
        tests++;
        if (idx > 4 || k != STEPS - 4 + idx || neg_tail !== nlit[idx]) begin
          fails++;
          $display("FAIL fold_neg idx=%0d got k=%0d neg=%b exp k=%0d", idx, k, neg_tail, STEPS - 4 + idx);
        end
        idx++;
      end
    end
    tests++;
    if (idx != 5) begin
      fails++;
      $display("FAIL fold_count got=%0d exp=5", idx);
    end
  endtask

  task automatic test_ce_stall();
    int edges = 1;
    bit seen = 1'b0;
    cycle(1'b1, 1'b1, rand_angle());
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b0, rand_angle());
      edges++;
    end
    for (int k = 0; k < 7; k++) begin
      cycle(1'b0, 1'($urandom_range(1)), rand_angle());
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL stall_hold k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
    while (!seen && edges < 20) begin
      cycle(1'b1, 1'b0, 0);
      edges++;
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL stall_model e=%0d got=%h exp=%h", edges, obs_vec(), exp_vec());
      end
      if (valid_tail === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen || edges - 1 != STEPS) begin
      fails++;
      $display("FAIL stall_latency got seen=%b edges=%0d exp edges=%0d", seen, edges - 1, STEPS);
    end
    repeat (3) cycle(1'b1, 1'b0, 0);
  endtask

  task automatic test_full_pipe();
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b1, 1'b1, rand_angle());
      tests++;
      if (inflight !== CW'(k < STEPS + 1 ? k : STEPS + 1) ||
          valid_tail !== (k >= STEPS + 1) || obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL full_pipe k=%0d got inflight=%0d tail=%b vec=%h exp vec=%h",
                 k, inflight, valid_tail, obs_vec(), exp_vec());
      end
    end
    for (int k = 0; k < 15; k++) begin
      cycle(1'b1, 1'b0, 0);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL full_drain k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      cycle($urandom_range(3) != 0, 1'($urandom_range(1)), rand_angle());
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL random k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_midflight();
    repeat (5) cycle(1'b1, 1'b1, rand_angle());
    repeat (3) cycle(1'b1, 1'b0, 0);
    reset = 1'b1;
    #1;
    tests++;
    if (obs_vec() !== '0) begin
      fails++;
      $display("FAIL reset_async got=%h exp=0", obs_vec());
    end
    model_clear();
    repeat (3) cycle(1'b1, 1'($urandom_range(1)), rand_angle());
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 1'b0, 0);
      tests++;
      if (obs_vec() !== exp_vec() || valid_tail !== 1'b0 || inflight !== '0) begin
        fails++;
        $display("FAIL reset_flush k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    ce         = 1'b0;
    in_valid   = 1'b0;
    t_angle_in = '0;
    model_clear();
    test_reset();
    test_no_fold();
    test_fold_b2b();
    test_ce_stall();
    test_full_pipe();
    test_random();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
